opb_single_master: RTL and testbench
====================================

# opb_single_master
Single-beat OPB bus master: turns a valid/ready command (read or write, one 32-bit word) from fabric logic into one OPB transaction and returns data/status on a valid/ready response port. It is the initiator side for the team's OPB slave registers and snapshot blocks, letting fabric logic read and write any OPB-mapped peripheral. Single clock domain (OPB_Clk); one outstanding transaction.
## Interface
- C_TIMEOUT_CYCLES, 16: XFER cycles without ack (toutSup low) before TIMEOUT status; range 2-255.
- C_MAX_RETRIES, 8: retry cycles tolerated before RETRY status; range 1-255.
- OPB_Clk  in  1  the only clock; all logic rising-edge.
- OPB_Rst  in  1  asynchronous, active-high reset.
- M_request  out  1  bus request to arbiter.
- M_select  out  1  master drives address phase.
- M_RNW  out  1  1=read, 0=write; 0 when not selected.
- M_ABus  out  [0:31]  address, bit 0 MSB; 0 when not selected.
- M_BE  out  [0:3]  byte enables; 0 when not selected.
- M_DBus  out  [0:31]  write data; 0 on reads and when not selected.
- M_seqAddr  out  1  constant 0 (no bursts).
- OPB_MGrant  in  1  arbiter grant.
- OPB_DBus  in  [0:31]  read data.
- OPB_xferAck  in  1  slave transfer acknowledge.
- OPB_errAck  in  1  slave error (valid with xferAck).
- OPB_retry  in  1  slave retry.
- OPB_toutSup  in  1  slave timeout suppress.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_rnw  in  1  1=read.
- cmd_addr  in  [31:0]  byte address; user[31-i] maps to bus bit i (same numeric value).
- cmd_be  in  [3:0]  byte enables, same mapping.
- cmd_wdata  in  [31:0]  write data, same mapping.
- rsp_valid  out  1  response present; held until rsp_ready.
- rsp_ready  in  1  response consumed.
- rsp_status  out  [1:0]  0=OK, 1=ERR, 2=TIMEOUT, 3=RETRY.
- rsp_rdata  out  [31:0]  read data (0 for writes and non-OK status).
## Operation
- FSM: IDLE, REQ, XFER, RESP. Reset: IDLE, every output 0 (cmd_ready 0 while OPB_Rst high, 1 first cycle after).
- IDLE: cmd_ready=1; on valid&ready register rnw/addr/be/wdata, clear retry and timeout counters -> REQ.
- REQ: M_request=1; OPB_MGrant sampled high -> XFER (M_request 0, M_select 1 next cycle).
- XFER, priority per cycle: xferAck&errAck -> RESP ERR; xferAck -> RESP OK (capture OPB_DBus on reads); retry -> retry_cnt+1, if new count = C_MAX_RETRIES -> RESP RETRY else -> REQ; timeout_cnt reaches C_TIMEOUT_CYCLES -> RESP TIMEOUT. M_select deasserts the cycle after leaving XFER.
- timeout_cnt increments each XFER cycle with toutSup=0, holds while toutSup=1, cleared on entering XFER.
- RESP: rsp_valid=1, payload stable; rsp_valid&rsp_ready -> IDLE. cmd_ready stays 0 until then.
- Reset mid-transaction: bus outputs drop immediately (async), command discarded, no response.
## Timing
- Best case (grant and ack immediate): accept at edge 0, M_request high cycle 1, M_select high cycle 2, xferAck in cycle 2, rsp_valid high cycle 3; rsp_ready high in cycle 3 -> cmd_ready high cycle 4.
- All outputs registered; no combinational path from OPB inputs to outputs.
- Acks arriving while M_select=0 are ignored.
## Configuration
- OPB_MASTER_TIMEOUT_EN defined: timeout counter built, TIMEOUT status reachable as above.
- Undefined: no counter; XFER waits indefinitely for xferAck/retry; status 2 never produced; C_TIMEOUT_CYCLES unused.
## Test plan
- Write 0xDEADBEEF to 0x0102C104, BE=0xF, grant/ack immediate -> M_ABus=0x0102C104 and M_DBus=0xDEADBEEF for exactly one cycle, status OK at cycle 3.
- Read 0x0102C100, slave returns 0x12345678 after 3 wait cycles -> rsp_rdata=0x12345678, status OK, M_DBus 0 throughout.
- Slave asserts xferAck+errAck -> status ERR, rsp_rdata=0.
- Retry asserted on every attempt, C_MAX_RETRIES=8 -> 8 request/select cycles, then status RETRY.
- No ack, toutSup high 10 cycles then low, C_TIMEOUT_CYCLES=16 -> TIMEOUT after 26 XFER cycles (macro defined); hang with macro undefined.
- rsp_ready held low 5 cycles, then OPB_Rst pulsed mid-XFER on next command -> response stable for 5 cycles; after reset all outputs 0, no rsp_valid.

Source files
------------

// File: rtl/opb_single_master.sv
// Single-beat OPB master: one valid/ready command -> one OPB transaction -> one valid/ready response.
// Define OPB_MASTER_TIMEOUT_EN to build the XFER timeout counter (TIMEOUT status).
module opb_single_master #(
  parameter int unsigned C_TIMEOUT_CYCLES = 16,
  parameter int unsigned C_MAX_RETRIES    = 8
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst,
  output logic        M_request,
  output logic        M_select,
  output logic        M_RNW,
  output logic [0:31] M_ABus,
  output logic [0:3]  M_BE,
  output logic [0:31] M_DBus,
  output logic        M_seqAddr,
  input  logic        OPB_MGrant,
  input  logic [0:31] OPB_DBus,
  input  logic        OPB_xferAck,
  input  logic        OPB_errAck,
  input  logic        OPB_retry,
  input  logic        OPB_toutSup,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rnw,
  input  logic [31:0] cmd_addr,
  input  logic [3:0]  cmd_be,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_status,
  output logic [31:0] rsp_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, RESP} state_t;

  localparam logic [1:0] STS_OK      = 2'd0;
  localparam logic [1:0] STS_ERR     = 2'd1;
  localparam logic [1:0] STS_TIMEOUT = 2'd2;
  localparam logic [1:0] STS_RETRY   = 2'd3;

  state_t      state, state_nxt;
  logic        rnw_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [7:0]  retry_cnt, retry_cnt_nxt;
  logic [1:0]  status_nxt;
  logic [31:0] rdata_nxt;
  logic        accept;
  logic        tout_hit;

  logic        request_d, select_d, rnw_d, cmd_ready_d, rsp_valid_d;
  logic [31:0] abus_d, dbus_d;
  logic [3:0]  be_d;

  // Bus-side order is bit 0 = MSB, so plain vector assignment keeps the numeric value.
  assign M_seqAddr = 1'b0;
  assign accept    = cmd_valid && cmd_ready;

`ifdef OPB_MASTER_TIMEOUT_EN
  logic [7:0] tout_cnt;

  assign tout_hit = !OPB_toutSup && (tout_cnt == 8'(C_TIMEOUT_CYCLES - 1));

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst)                                tout_cnt <= '0;
    else if (state != XFER && state_nxt == XFER) tout_cnt <= '0;
    else if (state == XFER && !OPB_toutSup)      tout_cnt <= tout_cnt + 8'd1;
  end
`else
  logic unused_tout;

  assign tout_hit    = 1'b0;
  assign unused_tout = ^{OPB_toutSup, 8'(C_TIMEOUT_CYCLES)};
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state      <= IDLE;
      retry_cnt  <= '0;
      rnw_q      <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      M_request  <= 1'b0;
      M_select   <= 1'b0;
      M_RNW      <= 1'b0;
      M_ABus     <= '0;
      M_BE       <= '0;
      M_DBus     <= '0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_status <= '0;
      rsp_rdata  <= '0;
    end else begin
      state      <= state_nxt;
      retry_cnt  <= retry_cnt_nxt;
      if (accept) begin
        rnw_q   <= cmd_rnw;
        addr_q  <= cmd_addr;
        be_q    <= cmd_be;
        wdata_q <= cmd_wdata;
      end
      M_request  <= request_d;
      M_select   <= select_d;
      M_RNW      <= rnw_d;
      M_ABus     <= abus_d;
      M_BE       <= be_d;
      M_DBus     <= dbus_d;
      cmd_ready  <= cmd_ready_d;
      rsp_valid  <= rsp_valid_d;
      rsp_status <= status_nxt;
      rsp_rdata  <= rdata_nxt;
    end
  end

  // NOTE: every combinational output gets a default first so no latch can be inferred.
  always_comb begin
    state_nxt     = state;
    retry_cnt_nxt = retry_cnt;
    status_nxt    = rsp_status;
    rdata_nxt     = rsp_rdata;
    case (state)
      IDLE: if (accept) begin
        state_nxt     = REQ;
        retry_cnt_nxt = '0;
      end
      REQ: if (OPB_MGrant) state_nxt = XFER;
      XFER: begin
        if (OPB_xferAck && OPB_errAck) begin
          state_nxt  = RESP;
          status_nxt = STS_ERR;
          rdata_nxt  = '0;
        end else if (OPB_xferAck) begin
          state_nxt  = RESP;
          status_nxt = STS_OK;
          rdata_nxt  = rnw_q ? OPB_DBus : 32'h0;
        end else if (OPB_retry) begin
          retry_cnt_nxt = retry_cnt + 8'd1;
          if (retry_cnt + 8'd1 == 8'(C_MAX_RETRIES)) begin
            state_nxt  = RESP;
            status_nxt = STS_RETRY;
            rdata_nxt  = '0;
          end else begin
            state_nxt = REQ;
          end
        end else if (tout_hit) begin
          state_nxt  = RESP;
          status_nxt = STS_TIMEOUT;
          rdata_nxt  = '0;
        end
      end
      RESP: if (rsp_valid && rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so none follows an OPB input combinationally.
  always_comb begin
    request_d   = (state_nxt == REQ);
    select_d    = (state_nxt == XFER);
    cmd_ready_d = (state_nxt == IDLE);
    rsp_valid_d = (state_nxt == RESP);
    rnw_d       = select_d && rnw_q;
    abus_d      = select_d ? addr_q : 32'h0;
    be_d        = select_d ? be_q : 4'h0;
    dbus_d      = (select_d && !rnw_q) ? wdata_q : 32'h0;
  end

endmodule

// File: tb/tb_opb_single_master.sv
// Directed bench for opb_single_master: scripted OPB slave, response scoreboard, bus-cycle monitor.
module tb_opb_single_master;

  typedef struct packed {
    logic [1:0]  status;
    logic [31:0] rdata;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        M_request, M_select, M_RNW, M_seqAddr;
  logic [0:31] M_ABus, M_DBus;
  logic [0:3]  M_BE;
  logic        OPB_MGrant = 1'b0;
  logic [0:31] OPB_DBus = '0;
  logic        OPB_xferAck = 1'b0, OPB_errAck = 1'b0, OPB_retry = 1'b0, OPB_toutSup = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_rnw = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_be = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_rdata;

  int   n_cmp = 0;
  int   n_mis = 0;
  int   sel_cyc = 0, req_cyc = 0, dbus_bad = 0;
  rsp_t exp_q[$];

  opb_single_master #(.C_TIMEOUT_CYCLES(16), .C_MAX_RETRIES(8)) dut (
    .OPB_Clk(clk), .OPB_Rst(rst),
    .M_request(M_request), .M_select(M_select), .M_RNW(M_RNW), .M_ABus(M_ABus),
    .M_BE(M_BE), .M_DBus(M_DBus), .M_seqAddr(M_seqAddr),
    .OPB_MGrant(OPB_MGrant), .OPB_DBus(OPB_DBus), .OPB_xferAck(OPB_xferAck),
    .OPB_errAck(OPB_errAck), .OPB_retry(OPB_retry), .OPB_toutSup(OPB_toutSup),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw), .cmd_addr(cmd_addr),
    .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_rdata(rsp_rdata)
  );

  always #5 clk = ~clk;

  // Bus activity monitor; write data must be zero whenever not a selected write.
  always @(negedge clk) begin
    if (M_select)  sel_cyc++;
    if (M_request) req_cyc++;
    if ((M_RNW || !M_select) && M_DBus != 32'h0) dbus_bad++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_bus(input string tag);
    check({tag, "_req"},  32'(M_request), 32'h0);
    check({tag, "_sel"},  32'(M_select),  32'h0);
    check({tag, "_rnw"},  32'(M_RNW),     32'h0);
    check({tag, "_abus"}, M_ABus,         32'h0);
    check({tag, "_be"},   32'(M_BE),      32'h0);
    check({tag, "_dbus"}, M_DBus,         32'h0);
    check({tag, "_seq"},  32'(M_seqAddr), 32'h0);
  endtask

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic send_cmd(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd);
    int n = 0;
    cmd_rnw = rnw; cmd_addr = addr; cmd_be = be; cmd_wdata = wd; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("cmd_ready_wait", 32'(cmd_ready), 32'h1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_sel(input int max_cyc);
    int n = 0;
    while (M_select !== 1'b1 && n < max_cyc) begin @(negedge clk); n++; end
    check("select_wait", 32'(M_select), 32'h1);
  endtask

  task automatic take_rsp(input int max_cyc);
    int   n = 0;
    rsp_t e;
    while (rsp_valid !== 1'b1 && n < max_cyc) begin @(negedge clk); n++; end
    check("rsp_valid_wait", 32'(rsp_valid), 32'h1);
    if (exp_q.size() == 0) begin
      n_cmp++; n_mis++;
      $error("FAIL scoreboard_empty: observed response expected none");
    end else begin
      e = exp_q.pop_front();
      check("rsp_status", 32'(rsp_status), 32'(e.status));
      check("rsp_rdata",  rsp_rdata,       e.rdata);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_drop",   32'(rsp_valid), 32'h0);
    check("ready_back", 32'(cmd_ready), 32'h1);
  endtask

  initial begin
    int   s0, r0, d0;
    rsp_t e;

    // Reset: every output low, including cmd_ready.
    repeat (2) @(negedge clk);
    check_idle_bus("rst");
    check("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(cmd_ready), 32'h1);

    // Best-case write: accept edge 0, request cycle 1, select cycle 2, response cycle 3.
    OPB_MGrant = 1'b1;
    s0 = sel_cyc; d0 = dbus_bad;
    exp_q.push_back('{2'd0, 32'h0});
    cmd_rnw = 1'b0; cmd_addr = 32'h0102C104; cmd_be = 4'hF; cmd_wdata = 32'hDEADBEEF;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("wr_c1_req",   32'(M_request), 32'h1);
    check("wr_c1_sel",   32'(M_select),  32'h0);
    check("wr_c1_ready", 32'(cmd_ready), 32'h0);
    @(negedge clk);
    check("wr_c2_sel",  32'(M_select),  32'h1);
    check("wr_c2_req",  32'(M_request), 32'h0);
    check("wr_c2_rnw",  32'(M_RNW),     32'h0);
    check("wr_c2_abus", M_ABus,         32'h0102C104);
    check("wr_c2_dbus", M_DBus,         32'hDEADBEEF);
    check("wr_c2_be",   32'(M_BE),      32'hF);
    OPB_xferAck = 1'b1;
    @(negedge clk);
    OPB_xferAck = 1'b0;
    check("wr_c3_valid", 32'(rsp_valid), 32'h1);
    check_idle_bus("wr_c3");
    take_rsp(2);
    check("wr_sel_cycles", 32'(sel_cyc - s0), 32'd1);

    // Read with delayed grant and three wait cycles; M_DBus must stay zero.
    OPB_MGrant = 1'b0;
    s0 = sel_cyc;
    exp_q.push_back('{2'd0, 32'h12345678});
    send_cmd(1'b1, 32'h0102C100, 4'hF, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    check("rd_req_hold", 32'(M_request), 32'h1);
    check("rd_no_sel",   32'(M_select),  32'h0);
    OPB_MGrant = 1'b1;
    wait_sel(5);
    check("rd_abus", M_ABus,         32'h0102C100);
    check("rd_rnw",  32'(M_RNW),     32'h1);
    repeat (3) @(negedge clk);
    OPB_xferAck = 1'b1; OPB_DBus = 32'h12345678;
    @(negedge clk);
    OPB_xferAck = 1'b0; OPB_DBus = 32'h0;
    take_rsp(3);
    check("rd_sel_cycles", 32'(sel_cyc - s0), 32'd4);
    check("rd_dbus_zero",  32'(dbus_bad - d0), 32'd0);

    // Error acknowledge: ERR status, read data forced to zero.
    exp_q.push_back('{2'd1, 32'h0});
    send_cmd(1'b1, 32'h0000_0040, 4'h3, 32'h0);
    wait_sel(5);
    OPB_xferAck = 1'b1; OPB_errAck = 1'b1; OPB_DBus = 32'hAAAA5555;
    @(negedge clk);
    OPB_xferAck = 1'b0; OPB_errAck = 1'b0; OPB_DBus = 32'h0;
    take_rsp(3);

    // Retry on every attempt: eight request and eight select cycles, then RETRY.
    s0 = sel_cyc; r0 = req_cyc;
    exp_q.push_back('{2'd3, 32'h0});
    OPB_retry = 1'b1;
    send_cmd(1'b0, 32'h0000_1000, 4'hF, 32'h5A5A5A5A);
    while (rsp_valid !== 1'b1 && (sel_cyc - s0) < 40) @(negedge clk);
    OPB_retry = 1'b0;
    take_rsp(2);
    check("retry_sel_cycles", 32'(sel_cyc - s0), 32'd8);
    check("retry_req_cycles", 32'(req_cyc - r0), 32'd8);

`ifdef OPB_MASTER_TIMEOUT_EN
    // Timeout: 10 suppressed cycles then 16 counted ones.
    s0 = sel_cyc;
    exp_q.push_back('{2'd2, 32'h0});
    OPB_toutSup = 1'b1;
    send_cmd(1'b1, 32'h0000_2000, 4'hF, 32'h0);
    wait_sel(5);
    repeat (10) @(negedge clk);
    OPB_toutSup = 1'b0;
    take_rsp(40);
    check("tout_sel_cycles", 32'(sel_cyc - s0), 32'd26);
`else
    // Without the timeout counter the transfer waits until the slave acknowledges.
    s0 = sel_cyc;
    exp_q.push_back('{2'd0, 32'h0});
    send_cmd(1'b0, 32'h0000_2000, 4'hF, 32'h0000_0001);
    wait_sel(5);
    repeat (40) @(negedge clk);
    check("hang_no_rsp", 32'(rsp_valid), 32'h0);
    check("hang_sel",    32'(M_select),  32'h1);
    OPB_xferAck = 1'b1;
    @(negedge clk);
    OPB_xferAck = 1'b0;
    take_rsp(2);
    check("hang_sel_cycles", 32'(sel_cyc - s0), 32'd41);
`endif

    // Response held for 5 cycles with rsp_ready low.
    exp_q.push_back('{2'd0, 32'hCAFEF00D});
    send_cmd(1'b1, 32'h0000_3000, 4'hF, 32'h0);
    wait_sel(5);
    OPB_xferAck = 1'b1; OPB_DBus = 32'hCAFEF00D;
    @(negedge clk);
    OPB_xferAck = 1'b0; OPB_DBus = 32'h0;
    e = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      check("hold_valid",  32'(rsp_valid),  32'h1);
      check("hold_status", 32'(rsp_status), 32'(e.status));
      check("hold_rdata",  rsp_rdata,       e.rdata);
      check("hold_ready",  32'(cmd_ready),  32'h0);
      @(negedge clk);
    end
    take_rsp(2);

    // Reset mid-XFER: outputs drop immediately, command discarded, no response.
    send_cmd(1'b0, 32'h0000_4000, 4'hF, 32'h1234ABCD);
    wait_sel(5);
    rst = 1'b1;
    #1;
    check_idle_bus("midrst");
    check("midrst_ready", 32'(cmd_ready), 32'h0);
    check("midrst_valid", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_idle_bus("after_rst");
    check("after_rst_valid", 32'(rsp_valid), 32'h0);
    check("after_rst_ready", 32'(cmd_ready), 32'h1);
    check("scoreboard_left", 32'(exp_q.size()), 32'd0);
    check("dbus_never_bad",  32'(dbus_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
